alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the Mini-SRC datapath. Width is set by a parameter.
//  Uses a valid/ready handshake. Mul/div are iterative and take WIDTH cycles; all other ops take 1 cycle.
//  Sits between the A/B operand latches and the Z_HI/Z_LO registers.
//  The control unit stalls on in_ready/out_valid instead of counting cycles.
// PARAMETERS
//  WIDTH     32  operand/result width; power of two, >=8
//  SHAMT_W   5   shift/rotate amount bits; must equal log2(WIDTH)
//  CNT_W     6   iteration counter bits; must equal log2(WIDTH)+1
// PORTS
//  clock      in   1        rising-edge clock
//  clear_n    in   1        asynchronous active-low reset
//  in_valid   in   1        operands/opcode valid
//  in_ready   out  1        ALU can accept (state IDLE)
//  inc_pc     in   1        override opcode: LO=A+1, HI=0
//  opcode     in   5        00011 add,00100 sub,00101 shr,00110 shra,00111 shl,01000 ror,
//                           01001 rol,01010 and,01011 or,01111 mul,10000 div,10001 neg,10010 not
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B (shift amount = b[SHAMT_W-1:0]; neg/not act on B)
//  out_valid  out  1        result valid, held until out_ready
//  out_ready  in   1        consumer accepts result
//  c_hi       out  WIDTH    high result (mul high word / div remainder, else 0)
//  c_lo       out  WIDTH    low result (mul low word / div quotient / op result)
//  div0       out  1        divide-by-zero flag, valid with out_valid
//  illegal    out  1        unsupported opcode flag, valid with out_valid
// BEHAVIOUR
//  Reset: all outputs 0, in_ready=1, FSM=IDLE, counter=0. Async assert aborts any op; no result produced.
//  FSM IDLE->(accept)->EXEC|DONE; EXEC->DONE when count==WIDTH; DONE->(out_valid&out_ready)->IDLE.
//  Accept = in_valid & in_ready; operands and opcode latched internally on accept.
//  Single-cycle ops: out_valid rises on the edge after accept (latency 1); in_ready=0 until the handshake.
//  mul: signed radix-2 Booth, WIDTH iterations in EXEC; out_valid at accept+WIDTH+1; {c_hi,c_lo}=a*b.
//  div: signed restoring on magnitudes, WIDTH iterations in EXEC; out_valid at accept+WIDTH+1.
//   c_lo = quotient truncated toward 0; c_hi = remainder with the sign of a.
//  div by b==0: skip EXEC, latency 1; c_lo=all ones, c_hi=a, div0=1.
//  add/sub: WIDTH-bit wrap, no carry out. shr logical, shra arithmetic. ror/rol use amount mod WIDTH.
//  neg: c_lo=-b (most-negative value maps to itself). not: c_lo=~b.
//  inc_pc=1 overrides opcode.
//  Unlisted opcode: c_lo=c_hi=0, illegal=1, latency 1.
//  Results and flags are registered and stable while out_valid=1 & out_ready=0.
//  They are cleared to 0 on the handshake.
//  in_valid while busy is ignored; the upstream holds it. Same-cycle handshake-out and accept is not allowed:
//  in_ready only rises in the cycle after DONE exits.
// CONFIGURATION
//  ALU_DIV_EN defined: divider built as above.
//  ALU_DIV_EN undefined: no divider logic. Opcode 10000 behaves as illegal (zeros, illegal=1, latency 1).
//  With the macro undefined, div0 is tied to 0.
// STRUCTURE
//  Package alu_seq_pkg: opcode localparams, FSM state encoding (IDLE/EXEC/DONE), op-class enum.
//  Op classes: SINGLE, MUL, DIV, ILLEGAL.
//  Sub-module alu_seq_iter: shared Booth/restoring datapath. It holds the {acc,q} register and counter.
//  alu_seq_iter has a start/done interface. Single-cycle ops are a combinational case in the top.
// TESTING
//  add a=7fffffff b=1 -> c_lo=80000000, c_hi=0, out_valid 1 cycle after accept.
//  mul a=-3 b=5 -> {c_hi,c_lo}=ffffffff_fffffff1, out_valid exactly 33 cycles after accept.
//  div a=-7 b=2 -> c_lo=fffffffd, c_hi=ffffffff; div b=0 a=9 -> c_lo=ffffffff, c_hi=9, div0=1.
//  Backpressure: hold out_ready=0 for 5 cycles after ror a=1 b=1 (c_lo=80000000).
//   Result stable, in_ready=0, second in_valid ignored.
//  clear_n pulsed low mid-mul (cycle 10 of EXEC).
//   Outputs 0 immediately, in_ready=1, no out_valid afterwards.
//  Opcode 11111 -> illegal=1, c_lo=0. Repeat opcode 10000 with ALU_DIV_EN undefined -> illegal=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Package for the Mini-SRC sequential ALU.
// Holds the opcode encodings, the controller state encoding and the
// operation classes that steer an accepted request either to the
// single-cycle result path or to the shared iterative datapath.
// Optional feature macro used by the design files: ALU_DIV_EN.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'b00,
        CLS_MUL     = 2'b01,
        CLS_DIV     = 2'b10,
        CLS_ILLEGAL = 2'b11
    } op_class_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath for the sequential ALU.
// One {acc,q} shift register serves both signed radix-2 Booth multiply and
// (when ALU_DIV_EN is defined) restoring division on operand magnitudes.
// The accumulator carries one guard bit so that Booth steps with a
// most-negative multiplicand cannot overflow.
// Ports:
//   clock, clear_n : clock and asynchronous active-low reset
//   start          : load operands and begin WIDTH iterations
//   is_div         : selects division for this run (multiply otherwise)
//   a, b           : operands (dividend/divisor or multiplier/multiplicand)
//   done           : high during the cycle whose edge performs the last step
//   hi, lo         : final result as it will stand after that last step
// Macro: ALU_DIV_EN builds the divider; without it is_div only blocks start.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic             qm1_r;
    logic [WIDTH-1:0] m_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic             go_s;
    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   mul_acc_s;
    logic [WIDTH-1:0] mul_q_s;
    logic [WIDTH:0]   acc_n_s;
    logic [WIDTH-1:0] q_n_s;

`ifdef ALU_DIV_EN
    logic             div_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   div_acc_s;
    logic [WIDTH-1:0] div_q_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    assign go_s = start;
`else
    // Without a divider a divide request must never occupy the datapath.
    assign go_s = start & ~is_div;
`endif

    assign done = busy_r && (cnt_r == LAST_CNT);

    // Booth step: add/subtract multiplicand by {q0,q-1}, then arithmetic shift right.
    always_comb begin
        m_ext_s = {m_r[WIDTH-1], m_r};
        case ({q_r[0], qm1_r})
            2'b01:   sum_s = acc_r + m_ext_s;
            2'b10:   sum_s = acc_r - m_ext_s;
            default: sum_s = acc_r;
        endcase
        mul_acc_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
        mul_q_s   = {sum_s[0], q_r[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    // Restoring step on magnitudes; both operands of the trial are below 2^WIDTH,
    // so the guard bit of the difference is a reliable borrow.
    always_comb begin
        a_mag_s   = a[WIDTH-1] ? -a : a;
        b_mag_s   = b[WIDTH-1] ? -b : b;
        shifted_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, m_r};
        if (trial_s[WIDTH]) begin
            div_acc_s = shifted_s;
            div_q_s   = {q_r[WIDTH-2:0], 1'b0};
        end else begin
            div_acc_s = trial_s;
            div_q_s   = {q_r[WIDTH-2:0], 1'b1};
        end
        quo_s = neg_q_r ? -div_q_s : div_q_s;
        rem_s = neg_r_r ? -div_acc_s[WIDTH-1:0] : div_acc_s[WIDTH-1:0];
    end
`endif

    // Select the next register contents and the final result for the active operation.
    always_comb begin
`ifdef ALU_DIV_EN
        if (div_r) begin
            acc_n_s = div_acc_s;
            q_n_s   = div_q_s;
            hi      = rem_s;
            lo      = quo_s;
        end else begin
            acc_n_s = mul_acc_s;
            q_n_s   = mul_q_s;
            hi      = mul_acc_s[WIDTH-1:0];
            lo      = mul_q_s;
        end
`else
        acc_n_s = mul_acc_s;
        q_n_s   = mul_q_s;
        hi      = mul_acc_s[WIDTH-1:0];
        lo      = mul_q_s;
`endif
    end

    // Operand load on start, then one iteration per clock until WIDTH steps are done.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc_r   <= '0;
            q_r     <= '0;
            qm1_r   <= 1'b0;
            m_r     <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
`ifdef ALU_DIV_EN
            div_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else if (go_s) begin
            acc_r   <= '0;
            qm1_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
`ifdef ALU_DIV_EN
            div_r   <= is_div;
            neg_q_r <= is_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= is_div & a[WIDTH-1];
            q_r     <= is_div ? a_mag_s : a;
            m_r     <= is_div ? b_mag_s : b;
`else
            q_r     <= a;
            m_r     <= b;
`endif
        end else if (busy_r) begin
            acc_r <= acc_n_s;
            q_r   <= q_n_s;
            qm1_r <= q_r[0];
            cnt_r <= cnt_r + ONE_CNT;
            if (cnt_r == LAST_CNT) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU for the Mini-SRC datapath with valid/ready handshakes.
// Single-cycle operations are decoded combinationally and registered on
// accept; multiply (and divide when built) run WIDTH steps in alu_seq_iter.
// Results are held until the consumer handshake, then cleared to zero.
// Ports:
//   clock, clear_n       : clock and asynchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready only in IDLE)
//   inc_pc, opcode, a, b : request (inc_pc forces LO=A+1, HI=0)
//   out_valid / out_ready: result handshake
//   c_hi, c_lo           : high/low result words
//   div0, illegal        : divide-by-zero and unsupported-opcode flags
// Macro: ALU_DIV_EN builds the divider; otherwise opcode 10000 is illegal
// and div0 never asserts.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inc_pc,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_hi,
    output logic [WIDTH-1:0] c_lo,
    output logic             div0,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           state_r;
    state_t           state_n_s;
    op_class_t        cls_s;
    logic             accept_s;
    logic             iter_start_s;
    logic             iter_done_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic [SHAMT_W-1:0] amt_s;
    logic [2*WIDTH-1:0] rot_wide_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;
    logic             res_div0_s;
    logic             res_ill_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] c_hi_r;
    logic [WIDTH-1:0] c_lo_r;
    logic             div0_r;
    logic             illegal_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign c_hi      = c_hi_r;
    assign c_lo      = c_lo_r;
    assign div0      = div0_r;
    assign illegal   = illegal_r;

    assign accept_s     = in_valid & in_ready_r;
    assign iter_start_s = accept_s & ((cls_s == CLS_MUL) || (cls_s == CLS_DIV));

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (iter_start_s),
        .is_div  (cls_s == CLS_DIV),
        .a       (a),
        .b       (b),
        .done    (iter_done_s),
        .hi      (iter_hi_s),
        .lo      (iter_lo_s)
    );

    // Classify the request and compute every single-cycle result.
    always_comb begin
        cls_s      = CLS_SINGLE;
        res_hi_s   = '0;
        res_lo_s   = '0;
        res_div0_s = 1'b0;
        res_ill_s  = 1'b0;
        amt_s      = b[SHAMT_W-1:0];
        rot_wide_s = '0;
        if (inc_pc) begin
            res_lo_s = a + ONE_W;
        end else begin
            case (opcode)
                OP_ADD:  res_lo_s = a + b;
                OP_SUB:  res_lo_s = a - b;
                OP_SHR:  res_lo_s = a >> amt_s;
                OP_SHRA: res_lo_s = $signed(a) >>> amt_s;
                OP_SHL:  res_lo_s = a << amt_s;
                // Rotates shift a doubled copy so amounts 0..WIDTH-1 need no special case.
                OP_ROR: begin
                    rot_wide_s = {a, a} >> amt_s;
                    res_lo_s   = rot_wide_s[WIDTH-1:0];
                end
                OP_ROL: begin
                    rot_wide_s = {a, a} << amt_s;
                    res_lo_s   = rot_wide_s[2*WIDTH-1:WIDTH];
                end
                OP_AND:  res_lo_s = a & b;
                OP_OR:   res_lo_s = a | b;
                OP_NEG:  res_lo_s = -b;
                OP_NOT:  res_lo_s = ~b;
                OP_MUL:  cls_s = CLS_MUL;
`ifdef ALU_DIV_EN
                OP_DIV: begin
                    if (b == '0) begin
                        res_lo_s   = '1;
                        res_hi_s   = a;
                        res_div0_s = 1'b1;
                    end else begin
                        cls_s = CLS_DIV;
                    end
                end
`endif
                default: begin
                    cls_s     = CLS_ILLEGAL;
                    res_ill_s = 1'b1;
                end
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((cls_s == CLS_MUL) || (cls_s == CLS_DIV)) begin
                        state_n_s = ST_EXEC;
                    end else begin
                        state_n_s = ST_DONE;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (iter_done_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Registered handshake flags and results; in_ready returns only after the
    // output handshake edge, so a new accept can never coincide with it.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            c_hi_r      <= '0;
            c_lo_r      <= '0;
            div0_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if ((cls_s != CLS_MUL) && (cls_s != CLS_DIV)) begin
                            out_valid_r <= 1'b1;
                            c_hi_r      <= res_hi_s;
                            c_lo_r      <= res_lo_s;
                            div0_r      <= res_div0_s;
                            illegal_r   <= res_ill_s;
                        end
                    end
                end
                ST_EXEC: begin
                    if (iter_done_s) begin
                        out_valid_r <= 1'b1;
                        c_hi_r      <= iter_hi_s;
                        c_lo_r      <= iter_lo_s;
                        div0_r      <= 1'b0;
                        illegal_r   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        c_hi_r      <= '0;
                        c_lo_r      <= '0;
                        div0_r      <= 1'b0;
                        illegal_r   <= 1'b0;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
